// File: rtl/argmax_stream.sv
// Streaming argmax over fixed-length score frames: tracks the best and runner-up
// score per frame and holds the registered result until downstream consumes it.
module argmax_stream #(
  parameter int INPUT_BITS = 12,
  parameter int NUM_CLASS  = 10,
  parameter int SIGNED_IN  = 1,
  localparam int IDX_BITS  = ($clog2(NUM_CLASS) > 1) ? $clog2(NUM_CLASS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [INPUT_BITS-1:0] in_data,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [IDX_BITS-1:0]   decision,
  output logic [INPUT_BITS-1:0] max_value,
  output logic [IDX_BITS-1:0]   second_idx,
  output logic [INPUT_BITS:0]   margin,
  output logic [0:0]            dbg_state
);

  // Handshake: a score transfers on a rising edge with valid_in && ready_in;
  // a result transfers on a rising edge with valid_out && ready_out.
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]            st_q, st_d;
  logic [IDX_BITS-1:0]   cnt_q, cnt_d;
  logic [INPUT_BITS-1:0] best_q, best_d;
  logic [IDX_BITS-1:0]   best_idx_q, best_idx_d;
  logic [INPUT_BITS-1:0] run_q, run_d;
  logic [IDX_BITS-1:0]   run_idx_q, run_idx_d;
  logic                  run_vld_q, run_vld_d;
  logic [IDX_BITS-1:0]   decision_q, decision_d;
  logic [INPUT_BITS-1:0] max_value_q, max_value_d;
  logic [IDX_BITS-1:0]   second_idx_q, second_idx_d;
  logic [INPUT_BITS:0]   margin_q, margin_d;
  logic                  accept;
  logic                  last;

  function automatic logic gt(input logic [INPUT_BITS-1:0] a,
                              input logic [INPUT_BITS-1:0] b);
    if (SIGNED_IN != 0) return $signed(a) > $signed(b);
    else                return a > b;
  endfunction

  function automatic logic [INPUT_BITS:0] ext(input logic [INPUT_BITS-1:0] a);
    if (SIGNED_IN != 0) return {a[INPUT_BITS-1], a};
    else                return {1'b0, a};
  endfunction

  assign ready_in   = (st_q == ST_ACCUM);
  assign valid_out  = (st_q == ST_HOLD);
  assign decision   = decision_q;
  assign max_value  = max_value_q;
  assign second_idx = second_idx_q;
  assign margin     = margin_q;
  assign dbg_state  = st_q;

  assign accept = valid_in && ready_in;
  assign last   = (cnt_q == IDX_BITS'(NUM_CLASS - 1));

  always_comb begin
    st_d         = st_q;
    cnt_d        = cnt_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    run_d        = run_q;
    run_idx_d    = run_idx_q;
    run_vld_d    = run_vld_q;
    decision_d   = decision_q;
    max_value_d  = max_value_q;
    second_idx_d = second_idx_q;
    margin_d     = margin_q;

    if (accept && !clear) begin
      if (cnt_q == '0) begin
        best_d     = in_data;
        best_idx_d = '0;
        run_vld_d  = 1'b0;
      end else if (gt(in_data, best_q)) begin
        run_d      = best_q;
        run_idx_d  = best_idx_q;
        run_vld_d  = 1'b1;
        best_d     = in_data;
        best_idx_d = cnt_q;
      end else if (!run_vld_q || gt(in_data, run_q)) begin
        run_d     = in_data;
        run_idx_d = cnt_q;
        run_vld_d = 1'b1;
      end

      // The final sample of the frame is folded in before the result loads.
      if (last) begin
        cnt_d        = '0;
        st_d         = ST_HOLD;
        decision_d   = best_idx_d;
        max_value_d  = best_d;
        second_idx_d = run_idx_d;
        margin_d     = ext(best_d) - ext(run_d);
      end else begin
        cnt_d = cnt_q + IDX_BITS'(1);
      end
    end

    if (st_q == ST_HOLD && ready_out) st_d = ST_ACCUM;

    if (clear) begin
      cnt_d     = '0;
      st_d      = ST_ACCUM;
      run_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= ST_ACCUM;
      cnt_q        <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      run_q        <= '0;
      run_idx_q    <= '0;
      run_vld_q    <= 1'b0;
      decision_q   <= '0;
      max_value_q  <= '0;
      second_idx_q <= '0;
      margin_q     <= '0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      run_q        <= run_d;
      run_idx_q    <= run_idx_d;
      run_vld_q    <= run_vld_d;
      decision_q   <= decision_d;
      max_value_q  <= max_value_d;
      second_idx_q <= second_idx_d;
      margin_q     <= margin_d;
    end
  end

endmodule
